// File: rtl/weight_update_pkg.sv
// Shared constants and FSM state type for the output-layer weight-update stage.
// All fixed-point values are scaled by SCALE (x1000).
package weight_update_pkg;

    localparam int N_OUT = 5;
    localparam int N_HID = 8;
    localparam int SCALE = 1000;
    localparam int D_W   = 10;
    localparam int W_W   = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CALC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/weight_delta_calc.sv
// Combinational weight step: two truncating x1000 multiplies, then a signed
// add/subtract at W_W+1 bits saturated back to the signed W_W range.
module weight_delta_calc #(
    parameter int W_W = weight_update_pkg::W_W
) (
    input  logic signed [W_W-1:0]                   w,
    input  logic        [weight_update_pkg::D_W-1:0] delta,
    input  logic        [weight_update_pkg::D_W-1:0] hid,
    input  logic        [weight_update_pkg::D_W-1:0] lr,
    input  logic                                    sign,
    output logic signed [W_W-1:0]                   w_new
);
    import weight_update_pkg::*;

    localparam int P_W  = 2 * D_W;
    localparam int Q_W  = D_W + 1;
    localparam int DP_W = 2 * D_W + 1;

    // A sign mismatch between the two top bits means the W_W+1 sum left the W_W range.
    function automatic logic signed [W_W-1:0] sat_weight(input logic signed [W_W:0] v);
        logic signed [W_W-1:0] r;
        if (v[W_W] != v[W_W-1]) begin
            if (v[W_W]) begin
                r = {1'b1, {(W_W-1){1'b0}}};
            end else begin
                r = {1'b0, {(W_W-1){1'b1}}};
            end
        end else begin
            r = v[W_W-1:0];
        end
        return r;
    endfunction

    logic        [P_W-1:0]  prod_s;
    logic        [Q_W-1:0]  p_scaled_s;
    logic        [DP_W-1:0] dw_prod_s;
    logic        [Q_W-1:0]  dw_s;
    logic signed [W_W:0]    w_ext_s;
    logic signed [W_W:0]    dw_ext_s;
    logic signed [W_W:0]    sum_s;

    // Scaled delta-weight and saturated update.
    always_comb begin
        prod_s     = P_W'(delta) * P_W'(hid);
        p_scaled_s = Q_W'(prod_s / P_W'(SCALE));
        dw_prod_s  = DP_W'(p_scaled_s) * DP_W'(lr);
        dw_s       = Q_W'(dw_prod_s / DP_W'(SCALE));
        w_ext_s    = {w[W_W-1], w};
        dw_ext_s   = $signed({{(W_W+1-Q_W){1'b0}}, dw_s});
        if (sign) begin
            sum_s = w_ext_s - dw_ext_s;
        end else begin
            sum_s = w_ext_s + dw_ext_s;
        end
        w_new = sat_weight(sum_s);
    end

endmodule

// File: rtl/weight_update_out.sv
// Output-layer weight update: latches deltas, activations and learning rate on
// start, then read-modify-writes every weight serially (READ, CALC, WRITE).
module weight_update_out #(
    parameter int N_OUT = weight_update_pkg::N_OUT,
    parameter int N_HID = weight_update_pkg::N_HID,
    parameter int W_W   = weight_update_pkg::W_W,
    parameter int A_W   = $clog2(N_OUT * N_HID)
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              start,
    input  logic [0:N_OUT-1]                                  sign0,
    input  logic [N_OUT-1:0][weight_update_pkg::D_W-1:0]      delta0,
    input  logic [N_HID-1:0][weight_update_pkg::D_W-1:0]      hid_out,
    input  logic [weight_update_pkg::D_W-1:0]                 lr,
    output logic [A_W-1:0]                                    w_addr,
    output logic                                              w_rd_en,
    input  logic signed [W_W-1:0]                             w_rd_data,
    output logic                                              w_wr_en,
    output logic signed [W_W-1:0]                             w_wr_data,
    output logic                                              busy,
    output logic                                              done
);
    import weight_update_pkg::*;

    localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int IW = (N_HID > 1) ? $clog2(N_HID) : 1;

    state_e                  state_r;
    state_e                  state_s;
    logic [JW-1:0]           j_r;
    logic [JW-1:0]           j_s;
    logic [IW-1:0]           i_r;
    logic [IW-1:0]           i_s;
    logic                    latch_s;
    logic [A_W-1:0]          addr_s;

    logic [0:N_OUT-1]              sign_r;
    logic [N_OUT-1:0][D_W-1:0]     delta_r;
    logic [N_HID-1:0][D_W-1:0]     hid_r;
    logic [D_W-1:0]                lr_r;

    logic signed [W_W-1:0]   w_new_s;
    logic [A_W-1:0]          w_addr_r;
    logic                    w_rd_en_r;
    logic                    w_wr_en_r;
    logic signed [W_W-1:0]   w_wr_data_r;
    logic                    busy_r;
    logic                    done_r;

    weight_delta_calc #(
        .W_W (W_W)
    ) u_calc (
        .w     (w_rd_data),
        .delta (delta_r[j_r]),
        .hid   (hid_r[i_r]),
        .lr    (lr_r),
        .sign  (sign_r[j_r]),
        .w_new (w_new_s)
    );

    // Next-state and index update; i walks hidden inputs, j walks output neurons.
    always_comb begin
        state_s = state_r;
        i_s     = i_r;
        j_s     = j_r;
        latch_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = READ;
                    i_s     = {IW{1'b0}};
                    j_s     = {JW{1'b0}};
                    latch_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            READ:  state_s = CALC;
            CALC:  state_s = WRITE;
            WRITE: begin
                if (i_r < IW'(N_HID - 1)) begin
                    i_s     = i_r + IW'(1);
                    state_s = READ;
                end else if (j_r < JW'(N_OUT - 1)) begin
                    i_s     = {IW{1'b0}};
                    j_s     = j_r + JW'(1);
                    state_s = READ;
                end else begin
                    state_s = DONE;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Address of the weight the next cycle works on.
    always_comb begin
        addr_s = A_W'(j_s) * A_W'(N_HID) + A_W'(i_s);
    end

    // State, index counters and operand latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            i_r     <= {IW{1'b0}};
            j_r     <= {JW{1'b0}};
            sign_r  <= '0;
            delta_r <= '0;
            hid_r   <= '0;
            lr_r    <= {D_W{1'b0}};
        end else begin
            state_r <= state_s;
            i_r     <= i_s;
            j_r     <= j_s;
            if (latch_s) begin
                sign_r  <= sign0;
                delta_r <= delta0;
                hid_r   <= hid_out;
                lr_r    <= lr;
            end
        end
    end

    // Outputs are registered from the next state so strobes line up with READ/WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_addr_r    <= {A_W{1'b0}};
            w_rd_en_r   <= 1'b0;
            w_wr_en_r   <= 1'b0;
            w_wr_data_r <= {W_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            w_rd_en_r <= (state_s == READ);
            w_wr_en_r <= (state_s == WRITE);
            busy_r    <= (state_s != IDLE);
            done_r    <= (state_s == DONE);
            if (state_s == READ || state_s == CALC || state_s == WRITE) begin
                w_addr_r <= addr_s;
            end else begin
                w_addr_r <= {A_W{1'b0}};
            end
            if (state_r == CALC) begin
                w_wr_data_r <= w_new_s;
            end
        end
    end

    assign w_addr    = w_addr_r;
    assign w_rd_en   = w_rd_en_r;
    assign w_wr_en   = w_wr_en_r;
    assign w_wr_data = w_wr_data_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
